// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
//   Definitions shared by the instruction stream loader and its word assembler:
//   the FSM state encoding, the word geometry, and the byte-insertion helper
//   that implements both byte orders.
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Shifts one byte into a partially assembled word.
  // Little endian shifts right, so the first byte ends up in bits [7:0] after
  // four insertions. Big endian shifts left, so the first byte ends up in
  // bits [31:24].
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] sr,
    input logic [7:0]        b,
    input logic              big_endian
  );
    if (big_endian) return {sr[WORD_W-9:0], b};
    else            return {b, sr[WORD_W-1:8]};
  endfunction

endpackage

// File: rtl/instr_stream_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
//   Collects bytes into a 32-bit word for the instruction stream loader.
//
//   Ports:
//     CLK, RST    clock, asynchronous active-high reset
//     clear       synchronous clear of the shift register and byte counter
//     byte_in     incoming byte
//     xfer        a byte transfer happens this cycle
//     word_next   shift register contents including the byte in flight
//     word_done   this transfer is the 4th byte of a word (combinational)
//
//   Parameter BIG_ENDIAN selects which end of the word the first byte lands in.
// -----------------------------------------------------------------------------
module word_assembler
  import instr_loader_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  input  logic              xfer,
  output logic [WORD_W-1:0] word_next,
  output logic              word_done
);

  logic [WORD_W-1:0] shift_q;
  logic [1:0]        cnt_q;

  // word_next is what the shift register becomes if this byte is taken; the
  // top latches it on word_done so the full word is available one cycle later.
  assign word_next = insert_byte(shift_q, byte_in, BIG_ENDIAN != 0);
  assign word_done = xfer && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (xfer) begin
      shift_q <= word_next;
      cnt_q   <= cnt_q + 2'd1;  // wraps 3 -> 0 at the end of each word
    end
  end

endmodule

// File: rtl/instr_stream_loader.sv
// -----------------------------------------------------------------------------
// instr_stream_loader
//   Loads the MIPS core's instruction memory from a byte-wide stream (e.g. a
//   UART receiver): four bytes form a word, words go to consecutive addresses
//   starting at 0, and cpu_run releases the core once the load is complete.
//
//   Ports:
//     CLK, RST    clock (rising edge), asynchronous active-high reset
//     start       one-cycle pulse, honoured only in IDLE or DONE
//     num_words   words to load, latched on start, clamped to 2**ADDR_W
//     byte_in     source byte
//     byte_valid  source byte valid
//     byte_ready  loader accepts a byte (transfer = byte_valid & byte_ready)
//     DATA_IN     word to instruction memory, held outside WRITE
//     w_enable    one-cycle write strobe
//     w_addr      word address of the current write, held outside WRITE
//     busy        a load is in progress
//     cpu_run     load complete, core released
//     csum_err    trailer checksum mismatch (checksum build only, else 0)
//
//   Parameters: ADDR_W (address width), BIG_ENDIAN (0: first byte -> [7:0]).
//
//   Build option: define INSTR_LOADER_CHECKSUM_EN to require a trailer word
//   equal to the modulo-2^32 sum of all loaded words before cpu_run is given.
// -----------------------------------------------------------------------------
module instr_stream_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [WORD_W-1:0] DATA_IN,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_addr,
  output logic              busy,
  output logic              cpu_run,
  output logic              csum_err
);

  // DEPTH = 2**ADDR_W, expressed at num_words width.
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q;          // clamped word count of this load
  logic [ADDR_W:0]   word_cnt_q;   // words written so far
  logic [WORD_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;

  logic              start_ok;
  logic [ADDR_W:0]   n_clamped;
  logic              last_word;
  logic              xfer;
  logic [WORD_W-1:0] word_next;
  logic              word_done;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign n_clamped = (num_words > DEPTH_V) ? DEPTH_V : num_words;
  assign last_word = (word_cnt_q == n_q - ONE_V);
  assign xfer      = byte_valid && byte_ready;

  word_assembler #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (start_ok),
    .byte_in   (byte_in),
    .xfer      (xfer),
    .word_next (word_next),
    .word_done (word_done)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
  logic              csum_err_q;
  logic              csum_ok;

  assign csum_ok  = (word_next == sum_q);
  assign csum_err = csum_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q      <= '0;
      csum_err_q <= 1'b0;
    end else if (start_ok) begin
      sum_q      <= '0;
      csum_err_q <= 1'b0;
    end else begin
      if (state_q == ST_WRITE)
        sum_q <= sum_q + data_q;
      if (state_q == ST_CHECK && word_done)
        csum_err_q <= !csum_ok;
    end
  end
`else
  assign csum_err = 1'b0;
`endif

  // State register, latched word count, write data/address, word counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_q        <= n_clamped;
        word_cnt_q <= '0;
      end else if (state_q == ST_WRITE) begin
        word_cnt_q <= word_cnt_q + ONE_V;
      end
      // Capture the word on its completing byte so WRITE can present it
      // immediately; the trailer in CHECK never reaches DATA_IN.
      if (state_q == ST_COLLECT && word_done) begin
        data_q <= word_next;
        addr_q <= word_cnt_q[ADDR_W-1:0];
      end
    end
  end

  assign DATA_IN = data_q;
  assign w_addr  = addr_q;

  // Next state and state-decoded outputs.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    w_enable   = 1'b0;
    busy       = 1'b0;
    cpu_run    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok)
          state_d = (n_clamped == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        w_enable = 1'b1;
        busy     = 1'b1;
        if (last_word)
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        else
          state_d = ST_COLLECT;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        // A bad trailer leaves the core held and returns to IDLE.
        if (word_done) state_d = csum_ok ? ST_DONE : ST_IDLE;
      end
`endif
      ST_DONE: begin
        cpu_run = 1'b1;
        if (start_ok)
          state_d = (n_clamped == '0) ? ST_DONE : ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_stream_loader
//   Two loaders (little and big endian) share one byte stream. A reference
//   model builds each expected word from the byte list with plain arithmetic
//   and predicts addresses, write timing, the trailer checksum outcome and the
//   end-of-load flags. Honours INSTR_LOADER_CHECKSUM_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_stream_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic [7:0]        byte_in;
  logic              byte_valid;

  logic              ready_le, we_le, busy_le, run_le, cerr_le;
  logic [31:0]       data_le;
  logic [ADDR_W-1:0] addr_le;
  logic              ready_be, we_be, busy_be, run_be, cerr_be;
  logic [31:0]       data_be;
  logic [ADDR_W-1:0] addr_be;

  instr_stream_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(0)) dut_le (
    .CLK(CLK), .RST(RST), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_le),
    .DATA_IN(data_le), .w_enable(we_le), .w_addr(addr_le),
    .busy(busy_le), .cpu_run(run_le), .csum_err(cerr_le)
  );

  instr_stream_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1)) dut_be (
    .CLK(CLK), .RST(RST), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_be),
    .DATA_IN(data_be), .w_enable(we_be), .w_addr(addr_be),
    .busy(busy_be), .cpu_run(run_be), .csum_err(cerr_be)
  );

  always #5 CLK = ~CLK;

  // Edge index: at a negedge, cyc equals the number of rising edges so far.
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_le[$], exp_be[$];
  int unsigned wr_edge_le[$], wr_edge_be[$];
  int unsigned x4_edge[$];      // edge of each word's 4th byte
  logic [7:0]  stim[$];

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3, input bit be);
    if (be) return (32'(b0) << 24) + (32'(b1) << 16) + (32'(b2) << 8) + 32'(b3);
    else    return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
  endfunction

  // Write monitors: every strobe must match the next predicted write.
  always @(negedge CLK) begin
    if (!RST && we_le) begin
      wr_edge_le.push_back(cyc + 1);
      if (exp_le.size() == 0) check("le_unexpected_write_pending", exp_le.size(), 1);
      else begin
        wr_t e;
        e = exp_le.pop_front();
        check("le_data", data_le, e.data);
        check("le_addr", addr_le, e.addr);
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && we_be) begin
      wr_edge_be.push_back(cyc + 1);
      if (exp_be.size() == 0) check("be_unexpected_write_pending", exp_be.size(), 1);
      else begin
        wr_t e;
        e = exp_be.pop_front();
        check("be_data", data_be, e.data);
        check("be_addr", addr_be, e.addr);
      end
    end
  end

  // Offers one byte after 'gap' idle cycles; returns the edge it was taken on.
  // Entered and left just after a rising edge.
  task automatic feed_byte(input logic [7:0] b, input int gap, output int unsigned edge_no);
    int waitc;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge CLK); #1; end
    end
    byte_valid = 1'b1;
    byte_in    = b;
    waitc      = 0;
    edge_no    = 0;
    forever begin
      @(negedge CLK);
      if (ready_le != ready_be) check("ready_le_vs_be", ready_be, ready_le);
      if (ready_le) begin
        edge_no = cyc + 1;
        @(posedge CLK); #1;
        break;
      end
      waitc++;
      if (waitc > 50) begin
        check("byte_accept_timeout", waitc, 0);
        @(posedge CLK); #1;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  // One complete load. Bytes come from stim (filled randomly if empty).
  task automatic do_load(input int n, input int gap_lo, input int gap_hi,
                         input bit mid_start, input bit bad_trailer);
    int          n_eff, t, nb;
    int unsigned e;
    logic [31:0] sum_le, sum_be;
    bit          exp_err_le, exp_err_be;
    wr_t         w;

    n_eff = (n > DEPTH) ? DEPTH : n;
    if (stim.size() == 0)
      for (int i = 0; i < 4 * n_eff; i++) stim.push_back(8'($urandom));
    check("stim_len", stim.size(), 4 * n_eff);

    exp_le.delete(); exp_be.delete();
    wr_edge_le.delete(); wr_edge_be.delete(); x4_edge.delete();
    sum_le = '0; sum_be = '0;
    for (int k = 0; k < n_eff; k++) begin
      w.addr = ADDR_W'(k);
      w.data = pack(stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3], 1'b0);
      exp_le.push_back(w);
      sum_le += w.data;
      w.data = pack(stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3], 1'b1);
      exp_be.push_back(w);
      sum_be += w.data;
    end
    exp_err_le = 1'b0;
    exp_err_be = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (n_eff > 0) begin
      logic [31:0] tr;
      tr = bad_trailer ? sum_le + 32'd1 : sum_le;
      for (int i = 0; i < 4; i++) stim.push_back(8'(tr >> (8 * i)));
      exp_err_le = (tr != sum_le);
      exp_err_be = (pack(tr[7:0], tr[15:8], tr[23:16], tr[31:24], 1'b1) != sum_be);
    end
`endif

    start = 1'b1; num_words = (ADDR_W + 1)'(n);
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("after_start_busy", busy_le, n_eff > 0);
    check("after_start_run",  run_le,  n_eff == 0);
    check("after_start_cerr", cerr_le, 0);
    @(posedge CLK); #1;

    nb = stim.size();
    for (int i = 0; i < nb; i++) begin
      if (mid_start && i == 5) begin
        start = 1'b1; num_words = (ADDR_W + 1)'($urandom);
      end
      feed_byte(stim[i], $urandom_range(gap_hi, gap_lo), e);
      start = 1'b0;
      if (i % 4 == 3 && i < 4 * n_eff) x4_edge.push_back(e);
    end
    byte_valid = 1'b0;
    stim.delete();

    t = 0;
    @(negedge CLK);
    while ((busy_le || busy_be) && t < 20) begin @(negedge CLK); t++; end
    check("done_timeout", t < 20, 1);
    check("le_writes_missing", exp_le.size(), 0);
    check("be_writes_missing", exp_be.size(), 0);
    check("le_cpu_run",  run_le,  !exp_err_le);
    check("be_cpu_run",  run_be,  !exp_err_be);
    check("le_csum_err", cerr_le, exp_err_le);
    check("be_csum_err", cerr_be, exp_err_be);
    check("le_busy_end", busy_le, 0);

    // Write timing: each write lands on the edge after its word's 4th byte.
    check("wr_count_le", wr_edge_le.size(), x4_edge.size());
    for (int k = 0; k < wr_edge_le.size() && k < x4_edge.size(); k++)
      if (wr_edge_le[k] != x4_edge[k] + 1)
        check("wr_latency", wr_edge_le[k] - x4_edge[k], 1);

    // Bytes offered after the load must not be accepted.
    @(posedge CLK); #1;
    byte_valid = 1'b1; byte_in = 8'($urandom);
    repeat (2) begin
      @(negedge CLK);
      check("idle_ready_le", ready_le, 0);
      check("idle_ready_be", ready_be, 0);
    end
    @(posedge CLK); #1;
    byte_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned e;
    RST = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", ready_le, 0);
    check("rst_we",    we_le,    0);
    check("rst_data",  data_le,  0);
    check("rst_addr",  addr_le,  0);
    check("rst_busy",  busy_le,  0);
    check("rst_run",   run_le,   0);
    check("rst_cerr",  cerr_le,  0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Reset mid-COLLECT after two bytes, then a clean single-word load.
    start = 1'b1; num_words = 8'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    feed_byte(8'hAA, 0, e);
    feed_byte(8'hBB, 0, e);
    byte_valid = 1'b0;
    RST = 1'b1;
    #1;
    check("async_rst_busy",  busy_le,  0);
    check("async_rst_ready", ready_le, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    stim = '{8'h78, 8'h56, 8'h34, 8'h12};
    do_load(1, 0, 0, 0, 0);
    check("t1_data_le", data_le, 32'h12345678);
    check("t1_addr_le", addr_le, 0);

    // Two words back-to-back: writes five cycles apart.
    stim = '{8'h78, 8'h56, 8'h34, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    stim.insert(3, 8'h12);
    do_load(2, 0, 0, 0, 0);
    check("t2_data_le", data_le, 32'hDEADBEEF);
    if (wr_edge_le.size() == 2) check("t2_spacing", wr_edge_le[1] - wr_edge_le[0], 5);
    else                        check("t2_write_count", wr_edge_le.size(), 2);

    // Big-endian word with 3-cycle gaps between bytes.
    stim = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load(1, 3, 3, 0, 0);
    check("t3_data_be", data_be, 32'h12345678);

    // Zero words, then a clamped oversize load.
    do_load(0, 0, 0, 0, 0);
    do_load(200, 0, 0, 0, 0);
    check("t4_last_addr", addr_le, DEPTH - 1);

    // start while busy is ignored.
    do_load(3, 0, 1, 1, 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    do_load(2, 0, 0, 0, 0);
    check("ck_good_cerr", cerr_le, 0);
    check("ck_good_run",  run_le,  1);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    do_load(2, 0, 0, 0, 1);
    check("ck_bad_cerr", cerr_le, 1);
    check("ck_bad_run",  run_le,  0);
`endif

    // Randomized loads.
    for (int it = 0; it < 25; it++) begin
      int n;
      n = (it == 12) ? 255 : $urandom_range(6, 0);
      do_load(n, 0, $urandom_range(3, 0), (n >= 2) && ($urandom_range(1, 0) == 1),
              $urandom_range(1, 0) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Feeds the pipelined MIPS core's instruction-load port (DATA_IN / w_enable) from a byte-wide SoC source, for example a UART receiver.
- Assembles 4 bytes into each 32-bit word, writes the words to sequential instruction-memory addresses, then asserts cpu_run to release the core.
- Sits between the SoC byte channel and MIPS_PIPE, acting as the writer for the core's load interface.

Parameters:
- ADDR_W, 7, instruction-memory address width (DEPTH = 2**ADDR_W = 128 words).
- BIG_ENDIAN, 0, byte order. 0: first byte goes to bits [7:0]. 1: first byte goes to bits [31:24].

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- num_words  in  ADDR_W+1  number of words to load; latched on start.
- byte_in  in  8  source byte.
- byte_valid  in  1  source byte is valid.
- byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid & byte_ready.
- DATA_IN  out  32  word to the core's instruction memory.
- w_enable  out  1  one-cycle write strobe.
- w_addr  out  ADDR_W  word address of the current write.
- busy  out  1  a load is in progress.
- cpu_run  out  1  load complete; core released from hold.
- csum_err  out  1  checksum mismatch; only meaningful with CHECKSUM_EN.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. byte_ready=0, w_enable=0, DATA_IN=0, w_addr=0, busy=0, cpu_run=0, csum_err=0. The byte counter, word counter and shift register clear.
- IDLE: all outputs low. On start, latch N = min(num_words, DEPTH), clear counters, then go to:
  - DONE if N==0 (no writes occur);
  - COLLECT otherwise.
- COLLECT: byte_ready=1, busy=1.
  - Each transfer shifts the byte into the assembly register and increments byte_cnt (0..3).
  - The transfer with byte_cnt==3 completes the word: next state is WRITE, and byte_ready drops in the following cycle.
  - byte_valid low simply stalls; there is no timeout.
- WRITE: exactly one cycle. w_enable=1, DATA_IN=assembled word, w_addr=word_cnt[ADDR_W-1:0], byte_ready=0. Then word_cnt++ and:
  - if word_cnt==N-1, go to DONE (or CHECK with CHECKSUM_EN);
  - otherwise go back to COLLECT.
- Latency: the first w_enable occurs exactly 1 cycle after the 4th byte transfer. Back-to-back bytes give one word per 5 cycles.
- DONE: cpu_run=1, busy=0, byte_ready=0. A new start restarts the load and drops cpu_run in the next cycle.
- Outside WRITE: DATA_IN and w_addr hold their last values; w_enable=0.
- start during COLLECT, WRITE or CHECK is ignored.
- num_words > DEPTH is clamped to DEPTH, so w_addr never wraps within a load.
- Reset mid-load abandons the partial word. Words already written remain in memory.
- Bytes offered in IDLE or DONE are not accepted, because byte_ready=0.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit modulo-2^32 sum of all written words is kept.
  - After the last WRITE, the state machine enters CHECK. CHECK assembles one more 4-byte word (byte_ready=1) and writes nothing.
  - On completion the assembled word is compared with the sum. csum_err=1 on mismatch, held until the next start or reset.
  - The block then enters DONE. cpu_run=1 only if there was no mismatch; on a mismatch the block returns to IDLE with csum_err=1.
- Without the macro: no CHECK state, no sum register, csum_err tied to 0.

Decomposition:
- Shared package instr_loader_pkg holds:
  - state encoding (IDLE, COLLECT, WRITE, CHECK, DONE);
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- One sub-module, word_assembler, holds the byte shift register, the 2-bit byte counter, endian selection and a word_done pulse. The top level keeps the FSM, word counter, address and checksum.

Test Plan:
- Reset mid-COLLECT after 2 bytes, then start with num_words=1 and bytes 78,56,34,12 -> a single w_enable with DATA_IN=0x12345678 at w_addr=0; no leftover bytes from before the reset.
- start with num_words=2, bytes 78,56,34,12,EF,BE,AD,DE sent back-to-back -> writes 0x12345678@0 then 0xDEADBEEF@1 five cycles apart; then cpu_run=1 and busy=0.
- BIG_ENDIAN=1, num_words=1, bytes 12,34,56,78 -> DATA_IN=0x12345678; byte_valid gaps of 3 cycles only delay the write.
- num_words=0 -> no w_enable and cpu_run=1 one cycle after start. num_words=200 -> exactly 128 writes at addresses 0..127.
- start pulsed while busy -> ignored, with no counter reset. A second start from DONE -> cpu_run drops and the load reruns from addr 0.
- CHECKSUM_EN, words 0x00000001 and 0x00000002:
  - trailer 0x00000003 -> csum_err=0, cpu_run=1;
  - trailer 0x00000004 -> csum_err=1, cpu_run=0.
